pipeline_ctrl: RTL and testbench

- Central sequencing block for the 4-stage core: fetch (s1), decode/operand fetch (s2), execute (s3), writeback.
- Tracks a valid bit per pipeline register group and generates the hold and kill (bubble) controls for the stage registers.
- Resolves redirect flushes, load-use stalls, memory wait states and debug halt/single-step.
- Maintains cycle, retire, stall and flush performance counters.

---
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake and status bundle between the core datapath and the pipeline
// sequencer. The slave side is the sequencer; the master side is the core.
interface pipeline_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             jump;
  logic             mem_busy;
  logic [4:0]       dec_rs1;
  logic             dec_rs1_used;
  logic [4:0]       dec_rs2;
  logic             dec_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_rd_we;
  logic             ex_mem_rd;
  logic             halt_req;
  logic             resume_req;
  logic             step_req;

  logic             hold_fe;
  logic             hold_de;
  logic             hold_ex;
  logic             kill_de;
  logic             kill_ex;
  logic [2:0]       valid;
  logic             halted;
  logic [WIDTH-1:0] cyc_cnt;
  logic [WIDTH-1:0] ret_cnt;
  logic [WIDTH-1:0] stall_cnt;
  logic [WIDTH-1:0] flush_cnt;

  modport master (
    output jump, mem_busy, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
           ex_rd, ex_rd_we, ex_mem_rd, halt_req, resume_req, step_req,
    input  hold_fe, hold_de, hold_ex, kill_de, kill_ex, valid, halted,
           cyc_cnt, ret_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  jump, mem_busy, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
           ex_rd, ex_rd_we, ex_mem_rd, halt_req, resume_req, step_req,
    output hold_fe, hold_de, hold_ex, kill_de, kill_ex, valid, halted,
           cyc_cnt, ret_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencer for the 4-stage core: tracks stage occupancy, produces the
// hold/kill controls for the stage registers, handles redirects, load-use
// bubbles, memory wait states and debug halt/step, and keeps perf counters.
module pipeline_ctrl #(
  parameter int WIDTH          = 32,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_v1;
  logic             r_v2;
  logic             r_v3;
  logic [WIDTH-1:0] r_cyc;
  logic [WIDTH-1:0] r_ret;
  logic [WIDTH-1:0] r_stall;
  logic [WIDTH-1:0] r_flush;

  logic             w_running;
  logic             w_adv;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_lu;
  logic             w_hold_fe;
  logic             w_hold_de;
  logic             w_hold_ex;
  logic             w_kill_de;
  logic             w_kill_ex;
  logic [WIDTH-1:0] w_flush_inc;

  // The pipe moves only when the core is allowed to run and memory is ready.
  assign w_running = (r_state == RUN) || (r_state == STEP);
  assign w_adv     = w_running && !bus.mem_busy;

  // A load in execute whose result decode needs right now costs one bubble.
  assign w_rs1_hit = bus.dec_rs1_used && (bus.dec_rs1 == bus.ex_rd);
  assign w_rs2_hit = bus.dec_rs2_used && (bus.dec_rs2 == bus.ex_rd);
  assign w_lu      = LOAD_USE_STALL && r_v1 && r_v2 && bus.ex_mem_rd &&
                     bus.ex_rd_we && (bus.ex_rd != 5'd0) &&
                     (w_rs1_hit || w_rs2_hit);

  // Only instructions still in s1/s2 are discarded by a redirect.
  assign w_flush_inc = WIDTH'(r_v1) + WIDTH'(r_v2);

  // State register for the debug run/halt/step sequencing.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  // Next debug state; a halt lets the advancing edge complete first and
  // resume beats step when both arrive while halted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN: begin
        if (bus.halt_req && w_adv) w_next = HALTED;
      end
      HALTED: begin
        if (bus.resume_req)    w_next = RUN;
        else if (bus.step_req) w_next = STEP;
      end
      STEP: begin
        if (w_adv) w_next = HALTED;
      end
      default: w_next = RUN;
    endcase
  end

  // Stage register controls: reset injects bubbles, a frozen pipe holds
  // everything, and a redirect overrides any load-use bubble.
  always_comb begin
    w_hold_fe = 1'b0;
    w_hold_de = 1'b0;
    w_hold_ex = 1'b0;
    w_kill_de = 1'b0;
    w_kill_ex = 1'b0;
    if (rst) begin
      w_kill_de = 1'b1;
      w_kill_ex = 1'b1;
    end else if (!w_adv) begin
      w_hold_fe = 1'b1;
      w_hold_de = 1'b1;
      w_hold_ex = 1'b1;
    end else if (bus.jump) begin
      w_kill_de = 1'b1;
      w_kill_ex = 1'b1;
    end else if (w_lu) begin
      w_hold_fe = 1'b1;
      w_kill_de = 1'b1;
    end
  end

  // Stage occupancy follows the same hold/kill decisions as the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= w_hold_fe ? r_v1 : 1'b1;
      r_v2 <= w_kill_de ? 1'b0 : r_v1;
      r_v3 <= w_kill_ex ? 1'b0 : r_v2;
    end
  end

  // Performance counters; all wrap silently at the counter width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc   <= '0;
      r_ret   <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_cyc <= r_cyc + 1'b1;
      if (w_adv && r_v3)          r_ret   <= r_ret + 1'b1;
      if (w_running && w_hold_fe) r_stall <= r_stall + 1'b1;
      if (w_adv && bus.jump)      r_flush <= r_flush + w_flush_inc;
    end
  end

  assign bus.hold_fe   = w_hold_fe;
  assign bus.hold_de   = w_hold_de;
  assign bus.hold_ex   = w_hold_ex;
  assign bus.kill_de   = w_kill_de;
  assign bus.kill_ex   = w_kill_ex;
  assign bus.valid     = {r_v3, r_v2, r_v1};
  assign bus.halted    = (r_state == HALTED);
  assign bus.cyc_cnt   = r_cyc;
  assign bus.ret_cnt   = r_ret;
  assign bus.stall_cnt = r_stall;
  assign bus.flush_cnt = r_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a directed walk through the main
// scenarios followed by a long randomized run, all checked against a
// behavioural model of stage occupancy, debug mode and counters.
module tb_pipeline_ctrl;

  localparam int WIDTH = 8;
  localparam bit LUS   = 1'b1;

  logic clk;
  logic rst;

  pipeline_ctrl_if #(.WIDTH(WIDTH)) bus ();

  pipeline_ctrl #(.WIDTH(WIDTH), .LOAD_USE_STALL(LUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       jump;
    logic       mem_busy;
    logic [4:0] dec_rs1;
    logic       dec_rs1_used;
    logic [4:0] dec_rs2;
    logic       dec_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_rd_we;
    logic       ex_mem_rd;
    logic       halt_req;
    logic       resume_req;
    logic       step_req;
  } stim_t;

  typedef struct packed {
    logic             hold_fe;
    logic             hold_de;
    logic             hold_ex;
    logic             kill_de;
    logic             kill_ex;
    logic [2:0]       valid;
    logic             halted;
    logic [WIDTH-1:0] cyc;
    logic [WIDTH-1:0] ret;
    logic [WIDTH-1:0] stall;
    logic [WIDTH-1:0] flush;
  } exp_t;

  typedef enum int { M_RUN, M_HALT, M_STEP } mode_t;

  exp_t  expQ[$];
  int    checks   = 0;
  int    failures = 0;
  bit    done     = 1'b0;

  // Reference model state: occupancy of s1/s2/s3, debug mode, counters.
  bit    occ[1:3];
  mode_t mode;
  int    cycN, retN, stallN, flushN;
  bit    lastJump, lastAdv;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic modelReset();
    occ[1] = 0; occ[2] = 0; occ[3] = 0;
    mode = M_RUN;
    cycN = 0; retN = 0; stallN = 0; flushN = 0;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   adv, lu, fe, de, ex, kd, kx;
    int   inDecodeMatch;
    @(negedge clk);
    rst              = s.rst;
    bus.jump         = s.jump;
    bus.mem_busy     = s.mem_busy;
    bus.dec_rs1      = s.dec_rs1;
    bus.dec_rs1_used = s.dec_rs1_used;
    bus.dec_rs2      = s.dec_rs2;
    bus.dec_rs2_used = s.dec_rs2_used;
    bus.ex_rd        = s.ex_rd;
    bus.ex_rd_we     = s.ex_rd_we;
    bus.ex_mem_rd    = s.ex_mem_rd;
    bus.halt_req     = s.halt_req;
    bus.resume_req   = s.resume_req;
    bus.step_req     = s.step_req;

    adv = !s.rst && (mode != M_HALT) && !s.mem_busy;
    inDecodeMatch = 0;
    if (s.dec_rs1_used && s.dec_rs1 == s.ex_rd) inDecodeMatch++;
    if (s.dec_rs2_used && s.dec_rs2 == s.ex_rd) inDecodeMatch++;
    lu = LUS && occ[1] && occ[2] && s.ex_mem_rd && s.ex_rd_we &&
         (s.ex_rd != 0) && (inDecodeMatch > 0);

    {fe, de, ex, kd, kx} = 5'b00000;
    if (s.rst)         {kd, kx} = 2'b11;
    else if (!adv)     {fe, de, ex} = 3'b111;
    else if (s.jump)   {kd, kx} = 2'b11;
    else if (lu)       {fe, kd} = 2'b11;

    e.hold_fe = fe; e.hold_de = de; e.hold_ex = ex;
    e.kill_de = kd; e.kill_ex = kx;
    e.valid   = {occ[3], occ[2], occ[1]};
    e.halted  = (mode == M_HALT);
    e.cyc     = WIDTH'(cycN);
    e.ret     = WIDTH'(retN);
    e.stall   = WIDTH'(stallN);
    e.flush   = WIDTH'(flushN);
    expQ.push_back(e);

    if (s.rst) begin
      modelReset();
      lastJump = 0;
      lastAdv  = 0;
    end else begin
      cycN++;
      if (mode != M_HALT && fe) stallN++;
      if (adv) begin
        retN += int'(occ[3]);
        if (s.jump) begin
          flushN += int'(occ[1]) + int'(occ[2]);
          occ[3] = 0; occ[2] = 0; occ[1] = 1;
        end else if (lu) begin
          occ[3] = occ[2]; occ[2] = 0;
        end else begin
          occ[3] = occ[2]; occ[2] = occ[1]; occ[1] = 1;
        end
      end
      case (mode)
        M_RUN:  if (s.halt_req && adv) mode = M_HALT;
        M_HALT: if (s.resume_req) mode = M_RUN;
                else if (s.step_req) mode = M_STEP;
        M_STEP: if (adv) mode = M_HALT;
        default: mode = M_RUN;
      endcase
      lastJump = s.jump;
      lastAdv  = adv;
    end
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("hold_fe",   int'(bus.hold_fe),   int'(e.hold_fe));
    cmp("hold_de",   int'(bus.hold_de),   int'(e.hold_de));
    cmp("hold_ex",   int'(bus.hold_ex),   int'(e.hold_ex));
    cmp("kill_de",   int'(bus.kill_de),   int'(e.kill_de));
    cmp("kill_ex",   int'(bus.kill_ex),   int'(e.kill_ex));
    cmp("valid",     int'(bus.valid),     int'(e.valid));
    cmp("halted",    int'(bus.halted),    int'(e.halted));
    cmp("cyc_cnt",   int'(bus.cyc_cnt),   int'(e.cyc));
    cmp("ret_cnt",   int'(bus.ret_cnt),   int'(e.ret));
    cmp("stall_cnt", int'(bus.stall_cnt), int'(e.stall));
    cmp("flush_cnt", int'(bus.flush_cnt), int'(e.flush));
  endtask

  // Monitor: every cycle the DUT presents its controls and status; compare
  // them against the oldest expectation, settled away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end else if (!done) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard: got empty queue expected an entry at %0t", $time);
      end
    end
  end

  // Safety net so the run always ends with a summary.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL timeout: got no completion expected finish before %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    bus.jump = 0; bus.mem_busy = 0; bus.dec_rs1 = 0; bus.dec_rs1_used = 0;
    bus.dec_rs2 = 0; bus.dec_rs2_used = 0; bus.ex_rd = 0; bus.ex_rd_we = 0;
    bus.ex_mem_rd = 0; bus.halt_req = 0; bus.resume_req = 0; bus.step_req = 0;
    modelReset();
    lastJump = 0;
    lastAdv  = 0;

    $display("[TB] directed scenarios");
    s = idle(); s.rst = 1;
    repeat (2) applyStimulus(s);
    repeat (6) applyStimulus(idle());

    s = idle(); s.jump = 1;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    s = idle(); s.ex_mem_rd = 1; s.ex_rd_we = 1; s.ex_rd = 5;
    s.dec_rs2 = 5; s.dec_rs2_used = 1;
    applyStimulus(s);
    applyStimulus(idle());
    s.ex_rd = 0; s.dec_rs2 = 0;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    s = idle(); s.mem_busy = 1;
    repeat (3) applyStimulus(s);
    repeat (2) applyStimulus(idle());

    s = idle(); s.halt_req = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());
    repeat (2) begin
      s = idle(); s.step_req = 1;
      applyStimulus(s);
      repeat (2) applyStimulus(idle());
    end
    s = idle(); s.resume_req = 1;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    s = idle(); s.jump = 1; s.ex_mem_rd = 1; s.ex_rd_we = 1; s.ex_rd = 7;
    s.dec_rs1 = 7; s.dec_rs1_used = 1;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    s = idle(); s.jump = 1; s.mem_busy = 1;
    repeat (2) applyStimulus(s);
    s.mem_busy = 0;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    s = idle(); s.jump = 1; s.halt_req = 1;
    applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.step_req = 1; s.resume_req = 1;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    s = idle(); s.mem_busy = 1; s.rst = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    $display("[TB] randomized run");
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.rst          = ($urandom_range(0, 249) == 0);
      s.mem_busy     = ($urandom_range(0, 4) == 0);
      if (lastJump && !lastAdv) s.jump = 1;
      else if (lastJump)        s.jump = 0;
      else                      s.jump = ($urandom_range(0, 6) == 0);
      s.dec_rs1      = 5'($urandom_range(0, 3));
      s.dec_rs1_used = 1'($urandom_range(0, 1));
      s.dec_rs2      = 5'($urandom_range(0, 3));
      s.dec_rs2_used = 1'($urandom_range(0, 1));
      s.ex_rd        = 5'($urandom_range(0, 3));
      s.ex_rd_we     = ($urandom_range(0, 3) != 0);
      s.ex_mem_rd    = 1'($urandom_range(0, 1));
      s.halt_req     = ($urandom_range(0, 24) == 0);
      s.resume_req   = ($urandom_range(0, 7) == 0);
      s.step_req     = ($urandom_range(0, 4) == 0);
      applyStimulus(s);
    end

    done = 1'b1;
    #5;
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
